playback_control: RTL and testbench

Keyboard command decoder and sample-rate strobe generator for the flash audio player. It consumes ASCII key events from the keyboard interface. It produces the player's direction and pause levels, a one-cycle restart pulse, and the periodic `startsamplenow` strobe. The strobe period is adjustable at run time through speed keys. All outputs drive the music player stage directly.

---
 rtl/playback_control.sv | 162 ++++++++++++++++
 tb/tb_playback_control.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_control.sv
// ---------------------------------------------------------------------------
// playback_control
//
// Keyboard command decoder and sample-rate strobe generator for the flash
// audio player. ASCII key events from the keyboard interface set the playback
// direction and pause levels, fire a one-cycle restart pulse, and nudge the
// sample period up or down. A free-running counter produces the periodic
// startsamplenow strobe from the current period.
//
// Ports:
//   clk            in   1          system clock, all state on rising edge
//   rst            in   1          synchronous active-high reset
//   key_valid      in   1          key present; each rising edge is one event
//   key_ascii      in   8          ASCII code, sampled in the event cycle
//   kybrd_forward  out  1          1 = play forward, 0 = play backward
//   kybrd_pause    out  1          1 = paused
//   kybrd_reset    out  1          one-cycle restart pulse
//   startsamplenow out  1          one-cycle pulse per sample period
//   divisor        out  DIV_WIDTH  current strobe period in clk cycles
// ---------------------------------------------------------------------------
module playback_control #(
    parameter int DIV_WIDTH   = 16,
    parameter int DIV_DEFAULT = 1136,
    parameter int DIV_MIN     = 568,
    parameter int DIV_MAX     = 2272,
    parameter int DIV_STEP    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [7:0]           key_ascii,
    output logic                 kybrd_forward,
    output logic                 kybrd_pause,
    output logic                 kybrd_reset,
    output logic                 startsamplenow,
    output logic [DIV_WIDTH-1:0] divisor
);

    localparam logic [DIV_WIDTH-1:0] L_DEFAULT = DIV_WIDTH'(DIV_DEFAULT);
    localparam logic [DIV_WIDTH-1:0] L_MIN     = DIV_WIDTH'(DIV_MIN);
    localparam logic [DIV_WIDTH-1:0] L_MAX     = DIV_WIDTH'(DIV_MAX);
    localparam logic [DIV_WIDTH-1:0] L_ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH:0]   L_STEP_W  = (DIV_WIDTH+1)'(DIV_STEP);
    localparam logic [DIV_WIDTH:0]   L_MIN_W   = {1'b0, L_MIN};
    localparam logic [DIV_WIDTH:0]   L_MAX_W   = {1'b0, L_MAX};

    // ASCII letter codes, upper case
    localparam logic [7:0] K_E = 8'h45;
    localparam logic [7:0] K_D = 8'h44;
    localparam logic [7:0] K_F = 8'h46;
    localparam logic [7:0] K_B = 8'h42;
    localparam logic [7:0] K_R = 8'h52;
    localparam logic [7:0] K_U = 8'h55;
    localparam logic [7:0] K_L = 8'h4C;
    localparam logic [7:0] K_N = 8'h4E;

    logic                 r_kvQ;
    logic                 r_forward;
    logic                 r_pause;
    logic                 r_resetPulse;
    logic                 r_strobe;
    logic [DIV_WIDTH-1:0] r_divisor;
    logic [DIV_WIDTH-1:0] r_cnt;

    logic                 w_keyEvent;
    logic [7:0]           w_keyUpper;
    logic [DIV_WIDTH:0]   w_divWide;
    logic [DIV_WIDTH:0]   w_divUp;
    logic [DIV_WIDTH:0]   w_divDown;
    logic                 w_cntWrap;
    logic                 w_nextForward;
    logic                 w_nextPause;
    logic                 w_nextResetPulse;
    logic [DIV_WIDTH-1:0] w_nextDivisor;

    // A key event is the first cycle key_valid is seen high; holding the key
    // does not repeat it. Clearing bit 5 folds lower-case letters onto upper
    // case, and no other code folds onto a listed letter.
    assign w_keyEvent = key_valid & ~r_kvQ;
    assign w_keyUpper = key_ascii & 8'hDF;

    // The divisor is stepped one bit wider than its register so that neither
    // the increment nor the decrement can wrap before the clamp is applied.
    // A set top bit on the decrement means it went below zero.
    assign w_divWide = {1'b0, r_divisor};
    assign w_divUp   = w_divWide + L_STEP_W;
    assign w_divDown = w_divWide - L_STEP_W;

    // Greater-or-equal rather than equality, so a divisor that shrinks below
    // the running count wraps on the next cycle instead of waiting for the
    // counter to roll all the way around.
    assign w_cntWrap = (r_cnt >= (r_divisor - L_ONE));

    // Key decode: each recognised key changes at most one piece of state;
    // everything else holds its value, and unknown keys are ignored.
    always_comb begin
        w_nextForward    = r_forward;
        w_nextPause      = r_pause;
        w_nextResetPulse = 1'b0;
        w_nextDivisor    = r_divisor;
        if (w_keyEvent) begin
            case (w_keyUpper)
                K_E: w_nextPause = 1'b0;
                K_D: w_nextPause = 1'b1;
                K_F: w_nextForward = 1'b1;
                K_B: w_nextForward = 1'b0;
                K_R: w_nextResetPulse = 1'b1;
                K_U: begin
                    if (w_divDown[DIV_WIDTH] || (w_divDown < L_MIN_W)) begin
                        w_nextDivisor = L_MIN;
                    end else begin
                        w_nextDivisor = w_divDown[DIV_WIDTH-1:0];
                    end
                end
                K_L: begin
                    if (w_divUp > L_MAX_W) begin
                        w_nextDivisor = L_MAX;
                    end else begin
                        w_nextDivisor = w_divUp[DIV_WIDTH-1:0];
                    end
                end
                K_N: w_nextDivisor = L_DEFAULT;
                default: ;
            endcase
        end
    end

    // All state and every output is registered here. Reset wins over any key
    // event or strobe wrap landing in the same cycle. The strobe counter runs
    // independently of pause; the player gates on kybrd_pause itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kvQ        <= 1'b0;
            r_forward    <= 1'b1;
            r_pause      <= 1'b1;
            r_resetPulse <= 1'b0;
            r_strobe     <= 1'b0;
            r_divisor    <= L_DEFAULT;
            r_cnt        <= '0;
        end else begin
            r_kvQ        <= key_valid;
            r_forward    <= w_nextForward;
            r_pause      <= w_nextPause;
            r_resetPulse <= w_nextResetPulse;
            r_divisor    <= w_nextDivisor;
            if (w_cntWrap) begin
                r_cnt    <= '0;
                r_strobe <= 1'b1;
            end else begin
                r_cnt    <= r_cnt + L_ONE;
                r_strobe <= 1'b0;
            end
        end
    end

    assign kybrd_forward  = r_forward;
    assign kybrd_pause    = r_pause;
    assign kybrd_reset    = r_resetPulse;
    assign startsamplenow = r_strobe;
    assign divisor        = r_divisor;

endmodule

// File: tb/tb_playback_control.sv
// ---------------------------------------------------------------------------
// tb_playback_control
//
// Self-checking bench for playback_control with a small period range
// (default 8, min 4, max 12, step 2). Each key press pushes the expected
// output state into a scoreboard queue; the state is popped and compared
// once the DUT has registered the event. Expected strobe periods are queued
// the same way and popped as each pulse arrives.
// ---------------------------------------------------------------------------
module tb_playback_control;

    localparam int DW     = 16;
    localparam int P_DEF  = 8;
    localparam int P_MIN  = 4;
    localparam int P_MAX  = 12;
    localparam int P_STEP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic [7:0]    key_ascii;
    logic          kybrd_forward;
    logic          kybrd_pause;
    logic          kybrd_reset;
    logic          startsamplenow;
    logic [DW-1:0] divisor;

    int checks   = 0;
    int failures = 0;

    // Bench-side expectation of the player state
    logic expFwd;
    logic expPause;
    int   expDiv;

    typedef struct {
        logic [7:0] key;
        logic       fwd;
        logic       pause;
        logic       rstp;
        int         div;
    } exp_t;

    exp_t sbq[$];
    int   periodQ[$];

    // 10 ns clock
    always #5 clk = ~clk;

    playback_control #(
        .DIV_WIDTH   (DW),
        .DIV_DEFAULT (P_DEF),
        .DIV_MIN     (P_MIN),
        .DIV_MAX     (P_MAX),
        .DIV_STEP    (P_STEP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_valid      (key_valid),
        .key_ascii      (key_ascii),
        .kybrd_forward  (kybrd_forward),
        .kybrd_pause    (kybrd_pause),
        .kybrd_reset    (kybrd_reset),
        .startsamplenow (startsamplenow),
        .divisor        (divisor)
    );

    // Expected effect of a single key on the bench model
    task automatic modelKey(input logic [7:0] k, output logic rstp);
        logic [7:0] u;
        u    = k & 8'hDF;
        rstp = 1'b0;
        case (u)
            8'h45: expPause = 1'b0;
            8'h44: expPause = 1'b1;
            8'h46: expFwd   = 1'b1;
            8'h42: expFwd   = 1'b0;
            8'h52: rstp     = 1'b1;
            8'h55: expDiv   = (expDiv - P_STEP < P_MIN) ? P_MIN : expDiv - P_STEP;
            8'h4C: expDiv   = (expDiv + P_STEP > P_MAX) ? P_MAX : expDiv + P_STEP;
            8'h4E: expDiv   = P_DEF;
            default: ;
        endcase
    endtask

    // One key press: key_valid high for one sampling edge, expected state
    // pushed to the scoreboard. Returns on the falling edge right after the
    // event edge, where the registered outputs are visible.
    task automatic applyStimulus(input logic [7:0] k);
        exp_t e;
        logic rp;
        @(negedge clk);
        key_valid = 1'b1;
        key_ascii = k;
        modelKey(k, rp);
        e.key   = k;
        e.fwd   = expFwd;
        e.pause = expPause;
        e.rstp  = rp;
        e.div   = expDiv;
        sbq.push_back(e);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Count falling edges until the strobe is seen, bounded by limit
    task automatic waitStrobe(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            cycles++;
            if (startsamplenow === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int c;
        bit ok;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        expFwd    = 1'b1;
        expPause  = 1'b1;
        expDiv    = P_DEF;
        repeat (3) @(negedge clk);
        checks++;
        if ({kybrd_forward, kybrd_pause, kybrd_reset, startsamplenow, divisor} !==
            {1'b1, 1'b1, 1'b0, 1'b0, DW'(P_DEF)}) begin
            failures++;
            $display("[TB] FAIL reset_state got fwd=%b pause=%b rst=%b strobe=%b div=%0d want 1 1 0 0 %0d",
                     kybrd_forward, kybrd_pause, kybrd_reset, startsamplenow, divisor, P_DEF);
        end
        rst = 1'b0;
        waitStrobe(4 * P_DEF, c, ok);
        checks++;
        if (!ok || c != P_DEF) begin
            failures++;
            $display("[TB] FAIL first_strobe got %0d cycles (seen=%0d) want %0d", c, ok, P_DEF);
        end
        repeat (4) periodQ.push_back(P_DEF);
        while (periodQ.size() > 0) begin
            int want;
            want = periodQ.pop_front();
            waitStrobe(4 * P_MAX, c, ok);
            checks++;
            if (!ok || c != want) begin
                failures++;
                $display("[TB] FAIL default_period got %0d (seen=%0d) want %0d", c, ok, want);
            end
        end
    endtask

    task automatic test_keys();
        logic [7:0] keys [6] = '{8'h65, 8'h44, 8'h62, 8'h46, 8'h52, 8'h78};
        exp_t e;
        foreach (keys[i]) begin
            applyStimulus(keys[i]);
            e = sbq.pop_front();
            checks++;
            if ({kybrd_forward, kybrd_pause, kybrd_reset, divisor} !==
                {e.fwd, e.pause, e.rstp, DW'(e.div)}) begin
                failures++;
                $display("[TB] FAIL key_%c got fwd=%b pause=%b rst=%b div=%0d want %b %b %b %0d",
                         e.key, kybrd_forward, kybrd_pause, kybrd_reset, divisor,
                         e.fwd, e.pause, e.rstp, e.div);
            end
            @(negedge clk);
            checks++;
            if (kybrd_reset !== 1'b0) begin
                failures++;
                $display("[TB] FAIL key_%c_reset_width got kybrd_reset=%b one cycle later want 0",
                         e.key, kybrd_reset);
            end
        end
    endtask

    task automatic test_speed_up();
        exp_t e;
        logic rp;
        int   c;
        bit   ok;
        // Key held high for 20 cycles counts as a single press
        @(negedge clk);
        key_valid = 1'b1;
        key_ascii = 8'h55;
        modelKey(8'h55, rp);
        e.key = 8'h55; e.fwd = expFwd; e.pause = expPause; e.rstp = rp; e.div = expDiv;
        sbq.push_back(e);
        repeat (20) @(negedge clk);
        e = sbq.pop_front();
        checks++;
        if (divisor !== DW'(e.div)) begin
            failures++;
            $display("[TB] FAIL hold_U got div=%0d want %0d", divisor, e.div);
        end
        key_valid = 1'b0;
        repeat (3) begin
            applyStimulus(8'h55);
            e = sbq.pop_front();
            checks++;
            if (divisor !== DW'(e.div)) begin
                failures++;
                $display("[TB] FAIL clamp_U got div=%0d want %0d", divisor, e.div);
            end
        end
        waitStrobe(4 * P_MAX, c, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL sync_fast no strobe within %0d cycles", 4 * P_MAX);
        end
        repeat (3) periodQ.push_back(P_MIN);
        while (periodQ.size() > 0) begin
            int want;
            want = periodQ.pop_front();
            waitStrobe(4 * P_MAX, c, ok);
            checks++;
            if (!ok || c != want) begin
                failures++;
                $display("[TB] FAIL fast_period got %0d (seen=%0d) want %0d", c, ok, want);
            end
        end
    endtask

    task automatic test_slow_down();
        logic [7:0] keys [5] = '{8'h4E, 8'h6C, 8'h4C, 8'h6C, 8'h6E};
        exp_t e;
        foreach (keys[i]) begin
            applyStimulus(keys[i]);
            e = sbq.pop_front();
            checks++;
            if (divisor !== DW'(e.div)) begin
                failures++;
                $display("[TB] FAIL slow_%c got div=%0d want %0d", e.key, divisor, e.div);
            end
        end
    endtask

    task automatic test_shrink();
        exp_t e;
        logic rp;
        int   c;
        bit   ok;
        repeat (2) begin
            applyStimulus(8'h4C);
            e = sbq.pop_front();
            checks++;
            if (divisor !== DW'(e.div)) begin
                failures++;
                $display("[TB] FAIL shrink_setup got div=%0d want %0d", divisor, e.div);
            end
        end
        // Counter is zero on the falling edge showing a strobe
        waitStrobe(4 * P_MAX, c, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL sync_slow no strobe within %0d cycles", 4 * P_MAX);
        end
        repeat (9) @(negedge clk);
        key_valid = 1'b1;
        key_ascii = 8'h4E;
        modelKey(8'h4E, rp);
        @(negedge clk);
        key_valid = 1'b0;
        checks++;
        if (divisor !== DW'(expDiv) || startsamplenow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL shrink_event got div=%0d strobe=%b want %0d 0",
                     divisor, startsamplenow, expDiv);
        end
        @(negedge clk);
        checks++;
        if (startsamplenow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL shrink_wrap got strobe=%b want 1", startsamplenow);
        end
        repeat (2) periodQ.push_back(P_DEF);
        while (periodQ.size() > 0) begin
            int want;
            want = periodQ.pop_front();
            waitStrobe(4 * P_MAX, c, ok);
            checks++;
            if (!ok || c != want) begin
                failures++;
                $display("[TB] FAIL shrink_period got %0d (seen=%0d) want %0d", c, ok, want);
            end
        end
    endtask

    task automatic test_reset_collision();
        logic [7:0] keys [3] = '{8'h62, 8'h65, 8'h4C};
        exp_t e;
        int   c;
        bit   ok;
        bit   sawPulse;
        foreach (keys[i]) begin
            applyStimulus(keys[i]);
            e = sbq.pop_front();
            checks++;
            if ({kybrd_forward, kybrd_pause, divisor} !== {e.fwd, e.pause, DW'(e.div)}) begin
                failures++;
                $display("[TB] FAIL collide_setup_%c got fwd=%b pause=%b div=%0d want %b %b %0d",
                         e.key, kybrd_forward, kybrd_pause, divisor, e.fwd, e.pause, e.div);
            end
        end
        waitStrobe(4 * P_MAX, c, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL sync_collide no strobe within %0d cycles", 4 * P_MAX);
        end
        // With divisor 10 the next wrap happens on the edge where cnt is 9;
        // reset and an R press land on that same edge.
        repeat (expDiv - 1) @(negedge clk);
        rst       = 1'b1;
        key_valid = 1'b1;
        key_ascii = 8'h52;
        @(negedge clk);
        rst       = 1'b0;
        key_valid = 1'b0;
        expFwd    = 1'b1;
        expPause  = 1'b1;
        expDiv    = P_DEF;
        checks++;
        if ({kybrd_forward, kybrd_pause, kybrd_reset, startsamplenow, divisor} !==
            {1'b1, 1'b1, 1'b0, 1'b0, DW'(P_DEF)}) begin
            failures++;
            $display("[TB] FAIL collide_reset got fwd=%b pause=%b rst=%b strobe=%b div=%0d want 1 1 0 0 %0d",
                     kybrd_forward, kybrd_pause, kybrd_reset, startsamplenow, divisor, P_DEF);
        end
        sawPulse = 1'b0;
        c        = 0;
        ok       = 1'b0;
        for (int i = 0; i < 4 * P_DEF; i++) begin
            @(negedge clk);
            c++;
            if (kybrd_reset === 1'b1) sawPulse = 1'b1;
            if (startsamplenow === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (sawPulse || !ok || c != P_DEF) begin
            failures++;
            $display("[TB] FAIL collide_after got pulse=%0d strobe_at=%0d (seen=%0d) want 0 %0d",
                     sawPulse, c, ok, P_DEF);
        end
    endtask

    initial begin
        $display("[TB] playback_control bench start");
        test_reset();
        test_keys();
        test_speed_up();
        test_slow_down();
        test_shrink();
        test_reset_collision();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain got %0d entries left want 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
